// File: rtl/ahb_rr_arbiter_if.sv
// Bus-side signal bundle between the AHB masters/slave mux and the round-robin arbiter.
interface ahb_rr_arbiter_if;
    localparam int unsigned N_MST = 4;
    localparam int unsigned IDX_W = 2;

    logic [N_MST-1:0] hbusreq;
    logic [N_MST-1:0] hlock;
    logic [1:0]       htrans;
    logic [2:0]       hburst;
    logic             hready;
    logic             hresp;
    logic [N_MST-1:0] hgrant;
    logic [IDX_W-1:0] hmaster;
    logic [IDX_W-1:0] hmaster_d;
    logic             hmastlock;

    // Arbiter side
    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmaster_d, hmastlock
    );

    // Masters / bus-mux side
    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// 4-master AHB round-robin arbiter with locked-transfer hold and optional fixed-burst hold.
// Define ARB_BURST_HOLD_EN to freeze the grant for the length of WRAP/INCR 4/8/16 bursts.
module ahb_rr_arbiter (
    input  logic            hclk,
    input  logic            hreset,
    ahb_rr_arbiter_if.slave bus
);
    localparam int unsigned N_MST = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {PARK, OWN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_next_c;
    logic             rr_found_c;
    logic             lock_nxt;
    logic             arb_c;
    logic             lock_hold_c;
    logic             burst_hold_c;
    logic             hold_c;

`ifdef ARB_BURST_HOLD_EN
    localparam int unsigned CNT_W     = 4;
    localparam logic [1:0]  TR_BUSY   = 2'd1;
    localparam logic [1:0]  TR_NONSEQ = 2'd2;
    localparam logic [1:0]  TR_SEQ    = 2'd3;

    logic [CNT_W-1:0] cnt, cnt_nxt, beats_c;

    // Beats remaining after the NONSEQ beat of a fixed-length burst
    always_comb begin
        unique case (bus.hburst)
            3'd2, 3'd3: beats_c = CNT_W'(3);
            3'd4, 3'd5: beats_c = CNT_W'(7);
            3'd6, 3'd7: beats_c = CNT_W'(15);
            default:    beats_c = '0;
        endcase
    end

    // Burst beat counter: load on NONSEQ, count SEQ, freeze on BUSY, clear on early end or error
    always_comb begin
        cnt_nxt = cnt;
        if (bus.hready) begin
            if (bus.hresp) begin
                cnt_nxt = '0;
            end else if (cnt != '0) begin
                unique case (bus.htrans)
                    TR_SEQ:  cnt_nxt = cnt - CNT_W'(1);
                    TR_BUSY: cnt_nxt = cnt;
                    default: cnt_nxt = '0;
                endcase
            end else if (bus.htrans == TR_NONSEQ) begin
                cnt_nxt = beats_c;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign burst_hold_c = (cnt_nxt != '0);
`else
    logic unused_bus_c;
    assign unused_bus_c = ^{bus.htrans, bus.hburst, bus.hresp};
    assign burst_hold_c = 1'b0;
`endif

    // Lock hold is independent of error responses; only the owner dropping lock or request ends it
    assign lock_hold_c = bus.hlock[bus.hmaster] & bus.hbusreq[bus.hmaster];
    assign hold_c      = lock_hold_c | burst_hold_c;

    // Round-robin search starting one past the last owner, wrapping back to it last
    always_comb begin
        rr_next_c  = ptr;
        rr_found_c = 1'b0;
        for (int unsigned i = 1; i <= N_MST; i++) begin
            if (!rr_found_c && bus.hbusreq[ptr + IDX_W'(i)]) begin
                rr_next_c  = ptr + IDX_W'(i);
                rr_found_c = 1'b1;
            end
        end
    end

    // Next-state and grant selection; the edge that releases a hold also arbitrates
    always_comb begin
        state_nxt = state;
        owner_nxt = bus.hmaster;
        ptr_nxt   = ptr;
        lock_nxt  = bus.hmastlock;
        arb_c     = 1'b0;
        if (bus.hready) begin
            unique case (state)
                HOLD: arb_c = !hold_c;
                default: begin
                    if (hold_c) begin
                        state_nxt = HOLD;
                    end else begin
                        arb_c = 1'b1;
                    end
                end
            endcase
            if (arb_c) begin
                if (rr_found_c) begin
                    state_nxt = OWN;
                    owner_nxt = rr_next_c;
                    ptr_nxt   = rr_next_c;
                end else begin
                    state_nxt = PARK;
                    owner_nxt = '0;
                end
                lock_nxt = bus.hlock[owner_nxt];
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state         <= PARK;
            ptr           <= '0;
            bus.hgrant    <= N_MST'(1);
            bus.hmaster   <= '0;
            bus.hmaster_d <= '0;
            bus.hmastlock <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            bus.hgrant    <= N_MST'(1) << owner_nxt;
            bus.hmaster   <= owner_nxt;
            bus.hmastlock <= lock_nxt;
            if (bus.hready) begin
                bus.hmaster_d <= bus.hmaster;
            end
        end
    end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench for ahb_rr_arbiter (burst tests follow ARB_BURST_HOLD_EN).
module tb_ahb_rr_arbiter;
    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic hclk;
    logic hreset;
    int   checks;
    int   errors;

    ahb_rr_arbiter_if bus ();

    ahb_rr_arbiter dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hreset      = 1'b1;
        bus.hbusreq = 4'b0000;
        bus.hlock   = 4'b0000;
        bus.htrans  = T_NONSEQ;
        bus.hburst  = 3'd0;
        bus.hready  = 1'b1;
        bus.hresp   = 1'b0;
        #2;
        checks++;
        if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0 || bus.hmaster_d !== 2'd0 || bus.hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL reset got grant=%b m=%0d md=%0d lock=%b exp 0001/0/0/0",
                     bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock);
        end
        step();
        hreset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0 || bus.hmastlock !== 1'b0) begin
                errors++;
                $display("FAIL park[%0d] got grant=%b m=%0d lock=%b exp 0001/0/0",
                         i, bus.hgrant, bus.hmaster, bus.hmastlock);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_m;
        logic [1:0] exp_d;
        logic [3:0] exp_g;
        bus.hbusreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_m = 2'(i + 1);
            exp_d = 2'(i);
            exp_g = 4'b0001 << exp_m;
            checks++;
            if (bus.hmaster !== exp_m || bus.hmaster_d !== exp_d || bus.hgrant !== exp_g) begin
                errors++;
                $display("FAIL rotation[%0d] got m=%0d md=%0d grant=%b exp m=%0d md=%0d grant=%b",
                         i, bus.hmaster, bus.hmaster_d, bus.hgrant, exp_m, exp_d, exp_g);
            end
        end
    endtask

    task automatic test_lock();
        bus.hbusreq = 4'b0000;
        step();
        checks++;
        if (bus.hmaster !== 2'd0 || bus.hgrant !== 4'b0001) begin
            errors++;
            $display("FAIL lock_park got m=%0d grant=%b exp 0/0001", bus.hmaster, bus.hgrant);
        end
        bus.hbusreq = 4'b0010;
        bus.hlock   = 4'b0010;
        step();
        checks++;
        if (bus.hmaster !== 2'd1 || bus.hmastlock !== 1'b1) begin
            errors++;
            $display("FAIL lock_grant got m=%0d lock=%b exp 1/1", bus.hmaster, bus.hmastlock);
        end
        bus.hbusreq = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.hmaster !== 2'd1 || bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold[%0d] got m=%0d grant=%b lock=%b exp 1/0010/1",
                         i, bus.hmaster, bus.hgrant, bus.hmastlock);
            end
        end
        bus.hlock = 4'b0000;
        step();
        checks++;
        if (bus.hmaster !== 2'd2 || bus.hgrant !== 4'b0100 || bus.hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL lock_release got m=%0d grant=%b lock=%b exp 2/0100/0",
                     bus.hmaster, bus.hgrant, bus.hmastlock);
        end
    endtask

    task automatic test_sole_requester();
        bus.hbusreq = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.hmaster !== 2'd2 || bus.hmaster_d !== 2'd2) begin
                errors++;
                $display("FAIL sole[%0d] got m=%0d md=%0d exp 2/2", i, bus.hmaster, bus.hmaster_d);
            end
        end
    endtask

    task automatic test_stall();
        bus.hbusreq = 4'b1111;
        bus.hready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.hmaster !== 2'd2 || bus.hmaster_d !== 2'd2 || bus.hgrant !== 4'b0100) begin
                errors++;
                $display("FAIL stall[%0d] got m=%0d md=%0d grant=%b exp 2/2/0100",
                         i, bus.hmaster, bus.hmaster_d, bus.hgrant);
            end
        end
        bus.hready = 1'b1;
        step();
        checks++;
        if (bus.hmaster !== 2'd3 || bus.hmaster_d !== 2'd2) begin
            errors++;
            $display("FAIL stall_resume got m=%0d md=%0d exp 3/2", bus.hmaster, bus.hmaster_d);
        end
        step();
        checks++;
        if (bus.hmaster !== 2'd0 || bus.hmaster_d !== 2'd3) begin
            errors++;
            $display("FAIL stall_next got m=%0d md=%0d exp 0/3", bus.hmaster, bus.hmaster_d);
        end
    endtask

`ifdef ARB_BURST_HOLD_EN
    task automatic test_burst_incr4();
        logic [1:0] tr [8];
        logic       rdy [8];
        logic [1:0] exp_m [8];
        tr    = '{T_NONSEQ, T_NONSEQ, T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_BUSY, T_SEQ};
        rdy   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_m = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        bus.hbusreq = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.htrans = tr[i];
            bus.hready = rdy[i];
            bus.hburst = (i >= 2) ? 3'd3 : 3'd0;
            step();
            checks++;
            if (bus.hmaster !== exp_m[i]) begin
                errors++;
                $display("FAIL incr4[%0d] got m=%0d exp %0d", i, bus.hmaster, exp_m[i]);
            end
        end
        bus.htrans = T_SEQ;
        step();
        checks++;
        if (bus.hmaster !== 2'd3 || bus.hgrant !== 4'b1000) begin
            errors++;
            $display("FAIL incr4_end got m=%0d grant=%b exp 3/1000", bus.hmaster, bus.hgrant);
        end
    endtask

    task automatic test_burst_error();
        bus.htrans = T_NONSEQ;
        bus.hburst = 3'd0;
        step();
        checks++;
        if (bus.hmaster !== 2'd0) begin
            errors++;
            $display("FAIL incr8_pre got m=%0d exp 0", bus.hmaster);
        end
        bus.hburst = 3'd5;
        step();
        bus.htrans = T_SEQ;
        step();
        checks++;
        if (bus.hmaster !== 2'd0) begin
            errors++;
            $display("FAIL incr8_hold got m=%0d exp 0", bus.hmaster);
        end
        bus.hresp = 1'b1;
        step();
        checks++;
        if (bus.hmaster !== 2'd1 || bus.hgrant !== 4'b0010) begin
            errors++;
            $display("FAIL incr8_error got m=%0d grant=%b exp 1/0010", bus.hmaster, bus.hgrant);
        end
        bus.hresp  = 1'b0;
        bus.htrans = T_NONSEQ;
        bus.hburst = 3'd0;
    endtask
`else
    task automatic test_no_burst_hold();
        logic [1:0] exp_m;
        bus.hbusreq = 4'b1111;
        bus.hburst  = 3'd5;
        for (int i = 0; i < 4; i++) begin
            bus.htrans = (i == 0) ? T_NONSEQ : T_SEQ;
            step();
            exp_m = 2'(i + 1);
            checks++;
            if (bus.hmaster !== exp_m) begin
                errors++;
                $display("FAIL no_hold[%0d] got m=%0d exp %0d", i, bus.hmaster, exp_m);
            end
        end
        bus.htrans = T_NONSEQ;
        bus.hburst = 3'd0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        logic [1:0] exp_m;
        bus.hbusreq = 4'b1111;
        bus.hburst  = 3'd7;
        for (int i = 0; i < 5; i++) begin
            bus.htrans = (i == 0) ? T_NONSEQ : T_SEQ;
            step();
`ifdef ARB_BURST_HOLD_EN
            exp_m = 2'd1;
`else
            exp_m = 2'(i + 1);
`endif
            checks++;
            if (bus.hmaster !== exp_m) begin
                errors++;
                $display("FAIL incr16[%0d] got m=%0d exp %0d", i, bus.hmaster, exp_m);
            end
        end
        #2;
        hreset = 1'b1;
        #1;
        checks++;
        if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0 || bus.hmaster_d !== 2'd0 || bus.hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got grant=%b m=%0d md=%0d lock=%b exp 0001/0/0/0",
                     bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock);
        end
        bus.hbusreq = 4'b0100;
        bus.htrans  = T_IDLE;
        bus.hburst  = 3'd0;
        #1;
        hreset = 1'b0;
        step();
        checks++;
        if (bus.hmaster !== 2'd2 || bus.hgrant !== 4'b0100 || bus.hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got m=%0d grant=%b lock=%b exp 2/0100/0",
                     bus.hmaster, bus.hgrant, bus.hmastlock);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_lock();
        test_sole_requester();
        test_stall();
`ifdef ARB_BURST_HOLD_EN
        test_burst_incr4();
        test_burst_error();
`else
        test_no_burst_hold();
`endif
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
